// File: rtl/ram_pipelined.sv
// ram_pipelined: word-addressed RAM with one write and one read channel per
// cycle, per-lane write masks and a READ_LATENCY-deep registered read path.
// After reset a sequencer walks every word writing zero; requests are only
// accepted once that sweep has finished and ready is high.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_CLEAR | zeroing word[clr_cnt_q], one word per cycle; ready low
// ST_RUN   | normal operation; ready high until the next reset
module ram_pipelined #(
  parameter int ADDRESS_BITS = 4,
  parameter int DATA_BITS    = 8,
  parameter int LANE_BITS    = 8,
  parameter int READ_LATENCY = 1
) (
  input  logic                           clock,
  input  logic                           reset,
  output logic                           ready,
  input  logic                           write_valid,
  input  logic [ADDRESS_BITS-1:0]        write_address,
  input  logic [DATA_BITS-1:0]           write_data,
  input  logic [DATA_BITS/LANE_BITS-1:0] write_mask,
  input  logic                           read_valid,
  input  logic [ADDRESS_BITS-1:0]        read_address,
  output logic [DATA_BITS-1:0]           read_data,
  output logic                           read_data_valid
);

  localparam int DEPTH = 2 ** ADDRESS_BITS;
  localparam int LANES = DATA_BITS / LANE_BITS;
  localparam int CW    = ADDRESS_BITS + 1;

  typedef enum logic {
    ST_CLEAR,
    ST_RUN
  } state_t;

  state_t state_q, state_d;
  // One bit wider than the address so the sweep end shows up as the MSB.
  logic [CW-1:0] clr_cnt_q, clr_cnt_d;
  logic          clr_we;
  logic          wr_acc;
  logic          rd_acc;

  logic [DATA_BITS-1:0] mem_q [0:DEPTH-1];

  logic [READ_LATENCY-1:0]                pipe_vld_q, pipe_vld_d;
  logic [READ_LATENCY-1:0][DATA_BITS-1:0] pipe_dat_q, pipe_dat_d;

  // State register and clear counter; reset always restarts the sweep at word 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // Next-state logic: advance the sweep, leave CLEAR right after the last word.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    clr_we    = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        clr_we    = 1'b1;
        clr_cnt_d = clr_cnt_q + CW'(1);
        if (clr_cnt_d[ADDRESS_BITS]) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_CLEAR;
      end
    endcase
  end

  assign ready  = (state_q == ST_RUN);
  assign wr_acc = write_valid && ready;
  assign rd_acc = read_valid && ready;

  // Storage: the clear sweep and accepted writes never overlap (CLEAR vs RUN).
  always_ff @(posedge clock) begin
    if (clr_we) begin
      mem_q[clr_cnt_q[ADDRESS_BITS-1:0]] <= '0;
    end else if (wr_acc) begin
      for (int l = 0; l < LANES; l++) begin
        if (write_mask[l]) begin
          mem_q[write_address][l*LANE_BITS +: LANE_BITS] <= write_data[l*LANE_BITS +: LANE_BITS];
        end
      end
    end
  end

  // Read pipeline next state: stage data only moves with a valid token, so the
  // last stage naturally holds its previous result between pulses. The array
  // read happens before the write at the same edge lands, giving read-first.
  always_comb begin
    pipe_vld_d    = '0;
    pipe_dat_d    = pipe_dat_q;
    pipe_vld_d[0] = rd_acc;
    if (rd_acc) begin
      pipe_dat_d[0] = mem_q[read_address];
    end
    for (int i = 1; i < READ_LATENCY; i++) begin
      pipe_vld_d[i] = pipe_vld_q[i-1];
      if (pipe_vld_q[i-1]) begin
        pipe_dat_d[i] = pipe_dat_q[i-1];
      end
    end
  end

  // Read pipeline registers; reset discards every in-flight read.
  always_ff @(posedge clock) begin
    if (reset) begin
      pipe_vld_q <= '0;
      pipe_dat_q <= '0;
    end else begin
      pipe_vld_q <= pipe_vld_d;
      pipe_dat_q <= pipe_dat_d;
    end
  end

  assign read_data       = pipe_dat_q[READ_LATENCY-1];
  assign read_data_valid = pipe_vld_q[READ_LATENCY-1];

endmodule

// File: tb/tb_ram_pipelined.sv
// tb_ram_pipelined: scoreboard bench for ram_pipelined with 16-bit words,
// two 8-bit lanes and a three-cycle read path.
module tb_ram_pipelined;

  localparam int AB    = 4;
  localparam int DB    = 16;
  localparam int LB    = 8;
  localparam int RL    = 3;
  localparam int LN    = DB / LB;
  localparam int DEPTH = 1 << AB;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          ready;
  logic          write_valid = 1'b0;
  logic [AB-1:0] write_address = '0;
  logic [DB-1:0] write_data = '0;
  logic [LN-1:0] write_mask = '0;
  logic          read_valid = 1'b0;
  logic [AB-1:0] read_address = '0;
  logic [DB-1:0] read_data;
  logic          read_data_valid;

  ram_pipelined #(
    .ADDRESS_BITS(AB),
    .DATA_BITS   (DB),
    .LANE_BITS   (LB),
    .READ_LATENCY(RL)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .ready          (ready),
    .write_valid    (write_valid),
    .write_address  (write_address),
    .write_data     (write_data),
    .write_mask     (write_mask),
    .read_valid     (read_valid),
    .read_address   (read_address),
    .read_data      (read_data),
    .read_data_valid(read_data_valid)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [DB-1:0] data;
    int            due;
    int            addr;
  } exp_t;

  exp_t          sb[$];
  logic [DB-1:0] model [DEPTH];
  bit            tb_run = 1'b0;
  int            tests_run = 0;
  int            fails = 0;

  // Result checker: every valid pulse must match the oldest expected read,
  // both in data and in the cycle it was due.
  always @(negedge clock) begin
    exp_t e;
    if (read_data_valid === 1'b1) begin
      tests_run++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_valid cycle %0d got data %h, expected no result", cyc, read_data);
      end else begin
        e = sb.pop_front();
        if (read_data !== e.data || cyc != e.due) begin
          fails++;
          $display("FAIL read_result addr %0d got %h at cycle %0d, expected %h at cycle %0d",
                   e.addr, read_data, cyc, e.data, e.due);
        end
      end
    end else if (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      tests_run++;
      fails++;
      $display("FAIL missing_result addr %0d got valid=%b at cycle %0d, expected %h due cycle %0d",
               e.addr, read_data_valid, cyc, e.data, e.due);
    end
  end

  // One clock cycle of stimulus; the model is updated read-first.
  task automatic do_cycle(input bit wv, input logic [AB-1:0] wa, input logic [DB-1:0] wd,
                          input logic [LN-1:0] wm, input bit rv, input logic [AB-1:0] ra);
    exp_t e;
    write_valid   = wv;
    write_address = wa;
    write_data    = wd;
    write_mask    = wm;
    read_valid    = rv;
    read_address  = ra;
    if (tb_run && rv) begin
      e.data = model[ra];
      e.due  = cyc + RL;
      e.addr = int'(ra);
      sb.push_back(e);
    end
    if (tb_run && wv) begin
      for (int l = 0; l < LN; l++) begin
        if (wm[l]) model[wa][l*LB +: LB] = wd[l*LB +: LB];
      end
    end
    @(posedge clock);
    #1;
    write_valid = 1'b0;
    read_valid  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) do_cycle(1'b0, '0, '0, '0, 1'b0, '0);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() > 0 && n < 20) begin
      idle(1);
      n++;
    end
    tests_run++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain_timeout got %0d reads outstanding, expected 0", sb.size());
      sb.delete();
    end
  endtask

  // Hold reset for one edge; reads that would land after that edge are dropped.
  task automatic apply_reset();
    reset  = 1'b1;
    tb_run = 1'b0;
    while (sb.size() > 0 && sb[sb.size()-1].due > cyc) void'(sb.pop_back());
    for (int a = 0; a < DEPTH; a++) model[a] = '0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    tests_run++;
    if (ready !== 1'b0 || read_data_valid !== 1'b0 || read_data !== '0) begin
      fails++;
      $display("FAIL reset_state got ready=%b valid=%b data=%h, expected ready=0 valid=0 data=0000",
               ready, read_data_valid, read_data);
    end
  endtask

  // Check ready stays low for the whole sweep, optionally driving requests
  // that must be ignored.
  task automatic run_clear(input bit inject);
    logic [AB-1:0] wa;
    for (int i = 0; i < DEPTH; i++) begin
      tests_run++;
      if (ready !== 1'b0) begin
        fails++;
        $display("FAIL clear_ready_low clear cycle %0d got ready=%b, expected 0", i, ready);
      end
      if (inject) begin
        wa = AB'((i > 0) ? i - 1 : 0);
        do_cycle(1'b1, wa, 16'hFFFF, 2'b11, 1'b1, wa);
      end else begin
        idle(1);
      end
    end
    tests_run++;
    if (ready !== 1'b1) begin
      fails++;
      $display("FAIL clear_ready_rise got ready=%b after %0d cycles, expected 1", ready, DEPTH);
    end
    tb_run = 1'b1;
  endtask

  task automatic read_all();
    for (int a = 0; a < DEPTH; a++) do_cycle(1'b0, '0, '0, '0, 1'b1, AB'(a));
    wait_drain();
  endtask

  task automatic fill_all();
    for (int a = 0; a < DEPTH; a++) do_cycle(1'b1, AB'(a), DB'(16'hA500 + a), 2'b11, 1'b0, '0);
  endtask

  task automatic test_reset();
    apply_reset();
    run_clear(1'b0);
    read_all();
  endtask

  task automatic test_mask();
    do_cycle(1'b1, 4'd3, 16'hABCD, 2'b11, 1'b0, '0);
    do_cycle(1'b1, 4'd3, 16'h1234, 2'b01, 1'b0, '0);
    do_cycle(1'b0, '0, '0, '0, 1'b1, 4'd3);
    do_cycle(1'b1, 4'd3, 16'h5678, 2'b10, 1'b0, '0);
    do_cycle(1'b1, 4'd3, 16'hFFFF, 2'b00, 1'b1, 4'd3);
    do_cycle(1'b0, '0, '0, '0, 1'b1, 4'd3);
    wait_drain();
  endtask

  task automatic test_pipeline();
    for (int a = 0; a < 4; a++) do_cycle(1'b1, AB'(a), DB'(16'h0011 + a), 2'b11, 1'b0, '0);
    for (int a = 0; a < 4; a++) do_cycle(1'b0, '0, '0, '0, 1'b1, AB'(a));
    wait_drain();
    idle(3);
    tests_run++;
    if (read_data !== 16'h0014 || read_data_valid !== 1'b0) begin
      fails++;
      $display("FAIL read_data_hold got data=%h valid=%b, expected data=0014 valid=0",
               read_data, read_data_valid);
    end
  endtask

  task automatic test_collision();
    do_cycle(1'b1, 4'd5, 16'h0077, 2'b11, 1'b1, 4'd5);
    do_cycle(1'b0, '0, '0, '0, 1'b1, 4'd5);
    wait_drain();
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 80; n++) begin
      do_cycle(1'($urandom_range(0, 1)), AB'($urandom), DB'($urandom), LN'($urandom),
               1'($urandom_range(0, 1)), AB'($urandom));
    end
    wait_drain();
  endtask

  task automatic test_reset_mid_clear();
    fill_all();
    apply_reset();
    idle(7);
    apply_reset();
    run_clear(1'b0);
    read_all();
    do_cycle(1'b1, 4'd4, 16'hBEEF, 2'b11, 1'b0, '0);
    do_cycle(1'b0, '0, '0, '0, 1'b1, 4'd4);
    apply_reset();
    run_clear(1'b0);
    read_all();
  endtask

  task automatic test_ignore_not_ready();
    fill_all();
    apply_reset();
    run_clear(1'b1);
    read_all();
  endtask

  initial begin
    @(posedge clock);
    #1;
    test_reset();
    test_mask();
    test_pipeline();
    test_collision();
    test_back_to_back();
    test_reset_mid_clear();
    test_ignore_not_ready();
    idle(2);
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got no finish by time %0t, expected completion", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ram_pipelined.md
Name: ram_pipelined

Overview:
- Synchronous RAM with independent write and read channels.
- Per-lane write masks and a configurable read latency pipeline.
- Self-clearing on reset: a sequencer zeroes every word.
- Generalised successor to the single-channel zero-delay RAM. Used as on-chip storage where a registered, multi-cycle read path is needed.

Parameters:
ADDRESS_BITS, 4, address width; depth = 2**ADDRESS_BITS words
DATA_BITS, 8, word width; must be an integer multiple of LANE_BITS
LANE_BITS, 8, width of one write-mask lane
READ_LATENCY, 1, cycles from read acceptance to read_data_valid; legal range 1..8

Ports:
clock  input  1  single clock; all logic on posedge
reset  input  1  synchronous, active-high
ready  output  1  high when requests are accepted; low during clear
write_valid  input  1  write request this cycle
write_address  input  ADDRESS_BITS  write word address
write_data  input  DATA_BITS  write data
write_mask  input  DATA_BITS/LANE_BITS  1 = update that lane; lane i = bits [i*LANE_BITS +: LANE_BITS]
read_valid  input  1  read request this cycle
read_address  input  ADDRESS_BITS  read word address
read_data  output  DATA_BITS  read result
read_data_valid  output  1  one-cycle pulse: read_data carries a result

Behaviour:
Reset values (cycle after reset sampled high):
- ready=0, read_data=0, read_data_valid=0.
- All read pipeline valid bits cleared.
- FSM in CLEAR, clear counter=0.

FSM:
- CLEAR
  - Each cycle writes 0 to word[counter] and increments counter.
  - After writing word 2**ADDRESS_BITS-1, go to RUN.
  - Clear takes exactly 2**ADDRESS_BITS cycles; ready rises on the following cycle.
- RUN
  - ready=1; stays until reset.
- reset high in any state, including mid-CLEAR:
  - Return to CLEAR with counter=0; clear restarts from word 0.
  - In-flight reads are discarded; no read_data_valid for them.

Handshake:
- A request is accepted on posedge when its valid=1 and ready=1.
- While ready=0, requests are ignored and dropped, not queued.
- No backpressure in RUN: one write and one read may be accepted every cycle.

Write path:
- An accepted write updates, at that posedge, only lanes whose mask bit=1.
- write_mask all-zero: no state change.

Read path:
- Read accepted at cycle N gives read_data_valid=1 at cycle N+READ_LATENCY, with the word value as of before the edge at N.
- Fully pipelined: back-to-back reads produce back-to-back results, in order.
- read_data holds its last value when read_data_valid=0.

Collision, same address same cycle:
- Read-first: the read returns the old data; the write takes effect.
- A read accepted at N+1 sees the write from N.

Widths:
- Addresses index words only; no wrap beyond the depth, since every address is in range.
- Clear counter is ADDRESS_BITS+1 bits wide, to detect the terminal count.

Test Plan:
1. Reset 1 cycle, ADDRESS_BITS=4 -> ready=0 for exactly 16 cycles then 1; reads of addresses 0..15 all return 0x00.
2. RUN, DATA_BITS=16, LANE_BITS=8: write addr 3 data 0xABCD mask 2'b11, then addr 3 data 0x1234 mask 2'b01 -> read addr 3 returns 0xAB34.
3. READ_LATENCY=3: write 0x11..0x14 to addr 0..3; reads issued at cycles 10,11,12,13 -> read_data_valid high cycles 13..16 with 0x11,0x12,0x13,0x14 in order.
4. Same cycle: write addr 5=0x77 and read addr 5, old value 0x00 -> read returns 0x00; read of addr 5 next cycle returns 0x77.
5. Reset asserted at clear cycle 7, and again with a read in flight -> clear restarts, ready=0 for 16 further cycles, no read_data_valid for the dropped read; all words read 0.
6. write_valid/read_valid asserted while ready=0 -> no memory change (a post-clear read returns 0) and no read_data_valid.
